// File: rtl/celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem_pkg.sv
// Shared types and field positions for the debug monitor RAM block.
package celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem_pkg;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_LOAD_RD,
    CMD_RD_NEXT,
    CMD_WR
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    J_ACC,
    J_DONE,
    AV_ACC,
    AV_DONE
  } state_e;

  localparam int unsigned STATUS_REG_OFFSET = 0;
  localparam int unsigned JDO_WR_DATA_MSB   = 34;
  localparam int unsigned JDO_WR_DATA_LSB   = 3;

  function automatic logic [31:0] status_word(input logic err, input logic rdy);
    return {30'b0, err, rdy};
  endfunction

endpackage

// File: rtl/celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem_if.sv
// Avalon debug_mem_slave signals between the CPU and the monitor RAM block.
interface celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem_if #(
  parameter int unsigned RAM_ADDR_W = 8
);
  logic [RAM_ADDR_W:0] address;
  logic                read;
  logic                write;
  logic [31:0]         writedata;
  logic [3:0]          byteenable;
  logic                debugaccess;
  logic [31:0]         readdata;
  logic                waitrequest;

  modport master (
    output address, read, write, writedata, byteenable, debugaccess,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable, debugaccess,
    output readdata, waitrequest
  );
endinterface

// File: rtl/celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem_ram.sv
// Single-port 32-bit RAM with byte enables and one-cycle registered read.
module celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem_ram #(
  parameter int unsigned ADDR_W    = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);
  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    q <= mem[addr];
  end
endmodule

// File: rtl/celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem.sv
// Debug monitor RAM + status register, arbitrating JTAG commands against the
// CPU's Avalon debug_mem_slave port.
module celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem
  import celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem_pkg::*;
#(
  parameter int unsigned RAM_ADDR_W   = 8,
  parameter int unsigned JDO_ADDR_LSB = 10,
  parameter string       INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [37:0]           jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_no_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem_if.slave avs,
  output logic [31:0]           MonDReg,
  output logic [RAM_ADDR_W-1:0] MonAReg,
  output logic                  monitor_ready,
  output logic                  monitor_error,
  output logic                  jtag_busy,
  output logic                  jtag_overrun
);
  state_e                state;
  cmd_e                  new_cmd, pend_cmd;
  logic                  pend_valid, accept, drop, multi_pulse;
  logic [RAM_ADDR_W-1:0] pend_addr;
  logic [31:0]           pend_data;

  logic [RAM_ADDR_W:0]   av_addr;
  logic                  av_write, av_dbg;
  logic [31:0]           av_wdata, av_rdata, readdata_q;
  logic [3:0]            av_be;
  logic                  waitrequest_q;

  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  ram_we;
  logic [3:0]            ram_be;
  logic [31:0]           ram_wdata, ram_q;

  logic                  unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  always_comb begin
    new_cmd = CMD_NONE;
    if (take_action_ocimem_b)         new_cmd = CMD_WR;
    else if (take_action_ocimem_a)    new_cmd = CMD_LOAD_RD;
    else if (take_no_action_ocimem_a) new_cmd = CMD_RD_NEXT;
  end

  assign multi_pulse = (take_action_ocimem_b & (take_action_ocimem_a | take_no_action_ocimem_a))
                     | (take_action_ocimem_a & take_no_action_ocimem_a);
  assign accept = (new_cmd != CMD_NONE) && !pend_valid;
  assign drop   = multi_pulse || ((new_cmd != CMD_NONE) && pend_valid);
  assign jtag_busy = pend_valid;

  // A drop in the same cycle as an accepted LOAD_RD keeps the overrun flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid   <= 1'b0;
      pend_cmd     <= CMD_NONE;
      pend_addr    <= '0;
      pend_data    <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      if (accept) begin
        pend_valid <= 1'b1;
        pend_cmd   <= new_cmd;
        pend_addr  <= jdo[JDO_ADDR_LSB +: RAM_ADDR_W];
        pend_data  <= jdo[JDO_WR_DATA_MSB:JDO_WR_DATA_LSB];
      end else if (state == J_DONE) begin
        pend_valid <= 1'b0;
        pend_cmd   <= CMD_NONE;
      end
      if (drop)                                     jtag_overrun <= 1'b1;
      else if (accept && new_cmd == CMD_LOAD_RD)    jtag_overrun <= 1'b0;
    end
  end

  // RAM port is driven from state so an async reset withdraws any write at once.
  always_comb begin
    ram_addr  = av_addr[RAM_ADDR_W-1:0];
    ram_we    = 1'b0;
    ram_be    = av_be;
    ram_wdata = av_wdata;
    if (state == J_ACC) begin
      ram_be    = '1;
      ram_wdata = pend_data;
      ram_we    = (pend_cmd == CMD_WR);
      case (pend_cmd)
        CMD_LOAD_RD: ram_addr = pend_addr;
        CMD_RD_NEXT: ram_addr = MonAReg + 1'b1;
        default:     ram_addr = MonAReg;
      endcase
    end else if (state == AV_ACC) begin
      ram_we = av_write && av_dbg && !av_addr[RAM_ADDR_W];
    end
  end

  celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem_ram #(
    .ADDR_W   (RAM_ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .be   (ram_be),
    .wdata(ram_wdata),
    .q    (ram_q)
  );

  always_comb begin
    av_rdata = '0;
    if (!av_addr[RAM_ADDR_W])
      av_rdata = ram_q;
    else if (av_addr[RAM_ADDR_W-1:0] == RAM_ADDR_W'(STATUS_REG_OFFSET))
      av_rdata = status_word(monitor_error, monitor_ready);
  end

  assign avs.readdata    = (state == AV_DONE) ? av_rdata : readdata_q;
  assign avs.waitrequest = waitrequest_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      waitrequest_q <= 1'b1;
      readdata_q    <= '0;
      MonDReg       <= '0;
      MonAReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      av_addr       <= '0;
      av_write      <= 1'b0;
      av_wdata      <= '0;
      av_be         <= '0;
      av_dbg        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_valid) begin
            state <= J_ACC;
          end else if (avs.read || avs.write) begin
            av_addr  <= avs.address;
            av_write <= avs.write;
            av_wdata <= avs.writedata;
            av_be    <= avs.byteenable;
            av_dbg   <= avs.debugaccess;
            state    <= AV_ACC;
          end
        end
        J_ACC: state <= J_DONE;
        J_DONE: begin
          case (pend_cmd)
            CMD_LOAD_RD: begin
              MonAReg <= pend_addr;
              MonDReg <= ram_q;
            end
            CMD_RD_NEXT: begin
              MonAReg <= MonAReg + 1'b1;
              MonDReg <= ram_q;
            end
            CMD_WR: begin
              MonAReg <= MonAReg + 1'b1;
              MonDReg <= pend_data;
            end
            default: ;
          endcase
          state <= IDLE;
        end
        AV_ACC: begin
          if (av_write && av_dbg && av_addr[RAM_ADDR_W] && av_be[0] &&
              av_addr[RAM_ADDR_W-1:0] == RAM_ADDR_W'(STATUS_REG_OFFSET)) begin
            monitor_ready <= av_wdata[0];
            monitor_error <= av_wdata[1];
          end
          waitrequest_q <= 1'b0;
          state         <= AV_DONE;
        end
        AV_DONE: begin
          readdata_q    <= av_rdata;
          waitrequest_q <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem.sv
// Directed self-checking bench for the debug monitor RAM block.
module tb_celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        monitor_ready, monitor_error, jtag_busy, jtag_overrun;
  int          n_checks = 0;
  int          n_fail = 0;

  celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem_if #(.RAM_ADDR_W(8)) avs_if ();

  celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem #(
    .RAM_ADDR_W(8), .JDO_ADDR_LSB(10), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .avs(avs_if),
    .MonDReg(MonDReg), .MonAReg(MonAReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the pulse(s) for one cycle; returns one cycle after the pulse (N+1).
  task automatic jtag_pulse(input logic a, input logic n, input logic b,
                            input logic [7:0] addr, input logic [31:0] data);
    jdo = {3'b000, data, 3'b000};
    if (a) jdo[17:10] = addr;
    take_action_ocimem_a = a;
    take_no_action_ocimem_a = n;
    take_action_ocimem_b = b;
    tick();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
  endtask

  // Avalon master transfer; lat = cycles until waitrequest=0, -1 on timeout.
  task automatic av_xfer(input logic wr, input logic [8:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic dbg,
                         output logic [31:0] rdata, output int lat);
    avs_if.address = addr;
    avs_if.read = !wr;
    avs_if.write = wr;
    avs_if.writedata = wdata;
    avs_if.byteenable = be;
    avs_if.debugaccess = dbg;
    lat = -1;
    rdata = 'x;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (avs_if.waitrequest === 1'b0) begin
        lat = i;
        rdata = avs_if.readdata;
        break;
      end
    end
    avs_if.read = 1'b0;
    avs_if.write = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
    avs_if.address = '0; avs_if.read = 0; avs_if.write = 0;
    avs_if.writedata = '0; avs_if.byteenable = '0; avs_if.debugaccess = 0;
    tick(); tick();
    n_checks++; if (MonDReg !== 32'h0) begin n_fail++; $display("FAIL reset_mondreg got %h exp 00000000", MonDReg); end
    n_checks++; if (MonAReg !== 8'h0) begin n_fail++; $display("FAIL reset_monareg got %h exp 00", MonAReg); end
    n_checks++; if (avs_if.waitrequest !== 1'b1) begin n_fail++; $display("FAIL reset_waitrequest got %b exp 1", avs_if.waitrequest); end
    n_checks++; if (avs_if.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got %h exp 0", avs_if.readdata); end
    n_checks++; if ({monitor_error, monitor_ready, jtag_overrun, jtag_busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {monitor_error, monitor_ready, jtag_overrun, jtag_busy}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_jtag_rw();
    logic [31:0] rd; int lat;
    av_xfer(1'b1, 9'h006, 32'hA5A50006, 4'hF, 1'b1, rd, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL av_write_latency got %0d exp 2", lat); end
    jtag_pulse(1, 0, 0, 8'h05, 32'h0); tick(); tick(); tick();
    n_checks++; if (MonAReg !== 8'h05) begin n_fail++; $display("FAIL load_rd_areg got %h exp 05", MonAReg); end
    jtag_pulse(0, 0, 1, 8'h00, 32'h12345678);
    n_checks++; if (jtag_busy !== 1'b1) begin n_fail++; $display("FAIL busy_n1 got %b exp 1", jtag_busy); end
    tick();
    n_checks++; if (jtag_busy !== 1'b1) begin n_fail++; $display("FAIL busy_n2 got %b exp 1", jtag_busy); end
    tick();
    n_checks++; if (jtag_busy !== 1'b1) begin n_fail++; $display("FAIL busy_n3 got %b exp 1", jtag_busy); end
    tick();
    n_checks++; if (MonDReg !== 32'h12345678) begin n_fail++; $display("FAIL wr_dreg got %h exp 12345678", MonDReg); end
    n_checks++; if (MonAReg !== 8'h06) begin n_fail++; $display("FAIL wr_areg got %h exp 06", MonAReg); end
    n_checks++; if (jtag_busy !== 1'b0) begin n_fail++; $display("FAIL busy_n4 got %b exp 0", jtag_busy); end
    jtag_pulse(1, 0, 0, 8'h05, 32'h0); tick(); tick(); tick();
    n_checks++; if (MonDReg !== 32'h12345678) begin n_fail++; $display("FAIL reload_dreg got %h exp 12345678", MonDReg); end
    jtag_pulse(0, 1, 0, 8'h00, 32'h0); tick(); tick();
    n_checks++; if (MonDReg !== 32'h12345678) begin n_fail++; $display("FAIL rdnext_early got %h exp 12345678", MonDReg); end
    tick();
    n_checks++; if (MonDReg !== 32'hA5A50006) begin n_fail++; $display("FAIL rdnext_dreg got %h exp a5a50006", MonDReg); end
    n_checks++; if (MonAReg !== 8'h06) begin n_fail++; $display("FAIL rdnext_areg got %h exp 06", MonAReg); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; int lat;
    av_xfer(1'b1, 9'h000, 32'h0BADF00D, 4'hF, 1'b1, rd, lat);
    jtag_pulse(1, 0, 0, 8'hFF, 32'h0); tick(); tick(); tick();
    n_checks++; if (MonAReg !== 8'hFF) begin n_fail++; $display("FAIL wrap_load got %h exp ff", MonAReg); end
    jtag_pulse(0, 1, 0, 8'h00, 32'h0); tick(); tick(); tick();
    n_checks++; if (MonAReg !== 8'h00) begin n_fail++; $display("FAIL wrap_areg got %h exp 00", MonAReg); end
    n_checks++; if (MonDReg !== 32'h0BADF00D) begin n_fail++; $display("FAIL wrap_dreg got %h exp 0badf00d", MonDReg); end
  endtask

  task automatic test_collision();
    avs_if.address = 9'h005; avs_if.read = 1'b1; avs_if.write = 1'b0;
    avs_if.byteenable = 4'hF; avs_if.debugaccess = 1'b1;
    jtag_pulse(1, 0, 0, 8'h06, 32'h0);
    n_checks++; if ({jtag_busy, avs_if.waitrequest} !== 2'b11) begin
      n_fail++; $display("FAIL coll_m1 busy/wait got %b exp 11", {jtag_busy, avs_if.waitrequest}); end
    tick();
    n_checks++; if (avs_if.waitrequest !== 1'b0) begin n_fail++; $display("FAIL coll_wait got %b exp 0", avs_if.waitrequest); end
    n_checks++; if (avs_if.readdata !== 32'h12345678) begin n_fail++; $display("FAIL coll_rdata got %h exp 12345678", avs_if.readdata); end
    avs_if.read = 1'b0;
    tick();
    n_checks++; if (avs_if.readdata !== 32'h12345678) begin n_fail++; $display("FAIL rdata_hold got %h exp 12345678", avs_if.readdata); end
    n_checks++; if (MonDReg !== 32'h0BADF00D) begin n_fail++; $display("FAIL coll_jtag_early got %h exp 0badf00d", MonDReg); end
    tick(); tick(); tick();
    n_checks++; if (MonDReg !== 32'hA5A50006) begin n_fail++; $display("FAIL coll_jtag_dreg got %h exp a5a50006", MonDReg); end
    n_checks++; if (MonAReg !== 8'h06) begin n_fail++; $display("FAIL coll_jtag_areg got %h exp 06", MonAReg); end
    n_checks++; if ({jtag_overrun, jtag_busy} !== 2'b00) begin
      n_fail++; $display("FAIL coll_flags got %b exp 00", {jtag_overrun, jtag_busy}); end
  endtask

  task automatic test_overrun();
    jtag_pulse(0, 1, 0, 8'h00, 32'h0);
    jtag_pulse(0, 1, 0, 8'h00, 32'h0);
    n_checks++; if (jtag_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set got %b exp 1", jtag_overrun); end
    tick(); tick();
    n_checks++; if (MonAReg !== 8'h07) begin n_fail++; $display("FAIL overrun_single got %h exp 07", MonAReg); end
    jtag_pulse(1, 1, 0, 8'h05, 32'h0); tick(); tick(); tick();
    n_checks++; if (MonAReg !== 8'h05) begin n_fail++; $display("FAIL priority_areg got %h exp 05", MonAReg); end
    n_checks++; if (jtag_overrun !== 1'b1) begin n_fail++; $display("FAIL priority_overrun got %b exp 1", jtag_overrun); end
    jtag_pulse(1, 0, 0, 8'h06, 32'h0);
    n_checks++; if (jtag_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got %b exp 0", jtag_overrun); end
    tick(); tick(); tick();
    n_checks++; if (MonDReg !== 32'hA5A50006) begin n_fail++; $display("FAIL after_clear_dreg got %h exp a5a50006", MonDReg); end
  endtask

  task automatic test_regs();
    logic [31:0] rd; int lat;
    av_xfer(1'b1, 9'h100, 32'h3, 4'h1, 1'b1, rd, lat);
    n_checks++; if ({monitor_error, monitor_ready} !== 2'b11) begin
      n_fail++; $display("FAIL status_write got %b exp 11", {monitor_error, monitor_ready}); end
    av_xfer(1'b0, 9'h100, 32'h0, 4'hF, 1'b1, rd, lat);
    n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL status_read got %h exp 3", rd); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL av_read_latency got %0d exp 2", lat); end
    av_xfer(1'b0, 9'h101, 32'h0, 4'hF, 1'b1, rd, lat);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL other_reg_read got %h exp 0", rd); end
    av_xfer(1'b1, 9'h100, 32'h0, 4'hF, 1'b0, rd, lat);
    av_xfer(1'b1, 9'h100, 32'h0, 4'h2, 1'b1, rd, lat);
    av_xfer(1'b0, 9'h100, 32'h0, 4'hF, 1'b1, rd, lat);
    n_checks++; if (rd !== 32'h3) begin n_fail++; $display("FAIL status_qualified got %h exp 3", rd); end
  endtask

  task automatic test_qualifiers();
    logic [31:0] rd; int lat;
    av_xfer(1'b1, 9'h010, 32'h11111111, 4'hF, 1'b1, rd, lat);
    av_xfer(1'b1, 9'h010, 32'hFFFFFFFF, 4'hF, 1'b0, rd, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL nodbg_latency got %0d exp 2", lat); end
    av_xfer(1'b0, 9'h010, 32'h0, 4'hF, 1'b1, rd, lat);
    n_checks++; if (rd !== 32'h11111111) begin n_fail++; $display("FAIL nodbg_write got %h exp 11111111", rd); end
    av_xfer(1'b1, 9'h010, 32'hAABBCCDD, 4'b0010, 1'b1, rd, lat);
    av_xfer(1'b0, 9'h010, 32'h0, 4'hF, 1'b1, rd, lat);
    n_checks++; if (rd !== 32'h1111CC11) begin n_fail++; $display("FAIL byteenable got %h exp 1111cc11", rd); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd; int lat;
    avs_if.address = 9'h010; avs_if.write = 1'b1; avs_if.read = 1'b0;
    avs_if.writedata = 32'hDEADBEEF; avs_if.byteenable = 4'hF; avs_if.debugaccess = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    avs_if.write = 1'b0;
    n_checks++; if (avs_if.waitrequest !== 1'b1) begin n_fail++; $display("FAIL midrst_wait got %b exp 1", avs_if.waitrequest); end
    n_checks++; if ({MonDReg, MonAReg} !== 40'h0) begin n_fail++; $display("FAIL midrst_mon got %h exp 0", {MonDReg, MonAReg}); end
    n_checks++; if ({monitor_error, monitor_ready, jtag_overrun, jtag_busy} !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_flags got %b exp 0000", {monitor_error, monitor_ready, jtag_overrun, jtag_busy}); end
    n_checks++; if (avs_if.readdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata got %h exp 0", avs_if.readdata); end
    tick();
    reset_n = 1'b1;
    tick();
    av_xfer(1'b0, 9'h010, 32'h0, 4'hF, 1'b1, rd, lat);
    n_checks++; if (rd !== 32'h1111CC11) begin n_fail++; $display("FAIL midrst_ram got %h exp 1111cc11", rd); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL midrst_latency got %0d exp 2", lat); end
  endtask

  initial begin
    test_reset();
    test_jtag_rw();
    test_wrap();
    test_collision();
    test_overrun();
    test_regs();
    test_qualifiers();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem.md
Name: celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem

Overview:
Downstream consumer of the debug slave's system-clock outputs (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a). It owns the 256x32 on-chip debug monitor RAM and the monitor status register, and arbitrates RAM access between JTAG commands and the CPU's debug_mem_slave Avalon port. It produces MonDReg, monitor_ready and monitor_error, which feed back into the debug slave.

Parameters:
RAM_ADDR_W, 8, word-address width of the monitor RAM (depth 2**RAM_ADDR_W).
JDO_ADDR_LSB, 10, LSB of the address field in jdo for LOAD_RD.
INIT_FILE, "", RAM initialisation file (monitor ROM image).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
jdo  in  38  JTAG data, stable while a take_* pulse is asserted
take_action_ocimem_a  in  1  one-cycle pulse: LOAD_RD
take_no_action_ocimem_a  in  1  one-cycle pulse: RD_NEXT
take_action_ocimem_b  in  1  one-cycle pulse: WR
address  in  RAM_ADDR_W+1  Avalon word address; MSB=1 selects register space
read  in  1  Avalon read
write  in  1  Avalon write
writedata  in  32  Avalon write data
byteenable  in  4  Avalon byte enables
debugaccess  in  1  write qualifier
readdata  out  32  Avalon read data, valid when waitrequest=0
waitrequest  out  1  Avalon stall
MonDReg  out  32  JTAG data return register
MonAReg  out  RAM_ADDR_W  JTAG address pointer
monitor_ready  out  1  monitor status bit 0
monitor_error  out  1  monitor status bit 1
jtag_busy  out  1  a JTAG command is pending or in service
jtag_overrun  out  1  sticky: a JTAG command was dropped

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE, pending cleared, MonDReg=0, MonAReg=0, readdata=0, monitor_ready=0, monitor_error=0, jtag_overrun=0, jtag_busy=0, waitrequest=1. RAM contents are retained. Reset mid-operation abandons the access; no partial write completes after the reset edge.
- Commands, priority WR > LOAD_RD > RD_NEXT when pulses coincide; lower-priority pulses are dropped and jtag_overrun is set.
  - LOAD_RD: MonAReg<=jdo[JDO_ADDR_LSB+RAM_ADDR_W-1:JDO_ADDR_LSB]; read RAM at the new address; MonDReg<=q.
  - RD_NEXT: MonAReg<=MonAReg+1, wrapping 255->0; read at the incremented address; MonDReg<=q.
  - WR: write jdo[34:3] to MonAReg with all bytes enabled; MonDReg<=jdo[34:3]; MonAReg<=MonAReg+1 (wrap) after the write.
- Pending register: 1-deep, holds command type plus jdo fields. A pulse in cycle N is captured and visible from N+1.
  - A pulse while pending is occupied is dropped and jtag_overrun is set.
  - jtag_overrun clears only on an accepted LOAD_RD, or on reset.
- FSM states: IDLE, J_ACC, J_DONE, AV_ACC, AV_DONE. RAM is synchronous single-port: inputs sampled at the edge ending an ACC state, q valid in the DONE state.
  - IDLE: pending visible -> J_ACC (JTAG wins over Avalon). Else read|write -> capture address/data/byteenable/debugaccess -> AV_ACC.
  - J_ACC -> J_DONE: MonDReg/MonAReg updated at the end of J_DONE; pending cleared -> IDLE.
  - AV_ACC -> AV_DONE: waitrequest=0 for exactly that cycle, readdata driven -> IDLE.
- JTAG latency: pulse at N -> MonDReg new value visible at N+4. jtag_busy is high N+1..N+3.
- Avalon latency: request first seen in IDLE at M -> waitrequest=0 at M+2.
  - Avalon and a JTAG pulse in the same IDLE cycle: Avalon is accepted first; JTAG is serviced immediately after.
  - The master holds the request until waitrequest=0. waitrequest=1 in every state except AV_DONE.
- Avalon RAM space (MSB=0):
  - Writes require debugaccess=1 and honour byteenable.
  - Writes with debugaccess=0 complete normally without modifying RAM.
- Avalon register space (MSB=1):
  - Offset 0 read = {30'b0, monitor_error, monitor_ready}.
  - Offset 0 write with debugaccess=1: monitor_ready<=writedata[0], monitor_error<=writedata[1] (byteenable[0] required).
  - Other offsets read 0; writes are ignored.
- readdata holds its last value outside AV_DONE.

Decomposition:
- Shared package: command-type enum (CMD_NONE, CMD_LOAD_RD, CMD_RD_NEXT, CMD_WR), FSM state enum, STATUS_REG_OFFSET=0, jdo field positions (WR data 34:3).
- One sub-module: celik_lab3_sys_nios2_gen2_0_cpu_debug_ocimem_ram, a single-port RAM with byte enables, 1-cycle read latency and INIT_FILE.

Test Plan:
- Reset mid-write: Avalon write 0xDEADBEEF, addr 0x10, debugaccess=1; assert reset_n=0 in AV_ACC -> all outputs at reset values, RAM[0x10] unchanged.
- JTAG write/read: LOAD_RD addr 0x05, then WR data 0x12345678 -> MonAReg=0x06. LOAD_RD 0x05 -> MonDReg=0x12345678 at pulse+4; RD_NEXT -> MonAReg=0x06.
- Wrap: LOAD_RD 0xFF then RD_NEXT -> MonAReg=0x00, MonDReg=RAM[0].
- Collision: Avalon read of addr 0x05 and a LOAD_RD pulse in the same cycle -> waitrequest=0 two cycles later with readdata=RAM[5]; JTAG result follows; no overrun.
- Overrun: two pulses 1 cycle apart -> second is dropped, jtag_overrun=1; next LOAD_RD clears it.
- Registers and qualifiers:
  - Write 0x3 to 0x100 -> monitor_ready=1, monitor_error=1; read 0x100 returns 0x3.
  - Write with debugaccess=0 -> RAM unchanged.
  - Byteenable 4'b0010 -> only bits 15:8 are modified.
